// File: rtl/pads_cfg_seq_pkg.sv
// Shared definitions for the pad output-enable configuration sequencer.
// State encodings, pad-window geometry and the pad address helper.
package pads_cfg_seq_pkg;

   localparam int          PAD_TOTAL        = 44;
   localparam int          IDX_W            = 6;
   localparam logic [31:0] PAD_BASE_DEFAULT = 32'h3000_6000;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WR   = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_RD   = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   function automatic logic [31:0] pad_addr(input logic [31:0]      base,
                                            input logic [IDX_W-1:0] idx);
      return base + {{(32-IDX_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/pads_cfg_wb_timer.sv
// Ack-wait counter: cleared outside a transfer, counts while waiting,
// flags expiry on the last permitted wait cycle.
module pads_cfg_wb_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic resetb,
   input  logic clr,
   input  logic run,
   output logic expired
);

   logic [7:0] tcnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         tcnt <= '0;
      end else if (clr) begin
         tcnt <= '0;
      end else if (run) begin
         tcnt <= tcnt + 8'd1;
      end
   end

   assign expired = (tcnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pads_cfg_seq.sv
// Wishbone initiator writing one OEN bit per pad into the pad-config window.
// Define PADS_CFG_READBACK_EN to read back and verify every pad after its write.
module pads_cfg_seq
   import pads_cfg_seq_pkg::*;
#(
   parameter int          NUM_PADS  = 38,
   parameter logic [31:0] BASE_ADDR = PAD_BASE_DEFAULT,
   parameter int          TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 start,
   input  logic [PAD_TOTAL-1:0] oen_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [IDX_W-1:0]     err_idx,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [3:0]           wbm_sel_o,
   output logic [31:0]          wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
   input  logic                 wbm_ack_i,
   input  logic [31:0]          wbm_dat_i
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADS - 1);

   logic [2:0]           state;
   logic [IDX_W-1:0]     idx;
   logic [PAD_TOTAL-1:0] mask_q;
   logic                 xfer;
   logic                 last_pad;
   logic                 t_expired;
   logic                 unused_dat;

   assign xfer     = (state == ST_WR) || (state == ST_RD);
   assign last_pad = (idx == LAST_IDX);

   pads_cfg_wb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .resetb  (resetb),
      .clr     (!xfer),
      .run     (xfer && !wbm_ack_i),
      .expired (t_expired)
   );

`ifdef PADS_CFG_READBACK_EN
   logic rd_phase;
   assign unused_dat = ^wbm_dat_i[31:1];
`else
   assign unused_dat = ^wbm_dat_i;
`endif

   // NOTE: every register, including the captured mask, takes the async
   // reset so no partial sequence survives a reset mid-transfer.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state   <= ST_IDLE;
         idx     <= '0;
         mask_q  <= '0;
         err     <= 1'b0;
         err_idx <= '0;
`ifdef PADS_CFG_READBACK_EN
         rd_phase <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mask_q  <= oen_mask;
                  idx     <= '0;
                  err     <= 1'b0;
                  err_idx <= '0;
                  state   <= ST_WR;
`ifdef PADS_CFG_READBACK_EN
                  rd_phase <= 1'b0;
`endif
               end
            end
            ST_WR: begin
               if (wbm_ack_i) begin
`ifdef PADS_CFG_READBACK_EN
                  rd_phase <= 1'b1;
                  state    <= ST_GAP;
`else
                  if (last_pad) begin
                     state <= ST_FIN;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= ST_GAP;
                  end
`endif
               end else if (t_expired) begin
                  err     <= 1'b1;
                  err_idx <= idx;
                  state   <= ST_FIN;
               end
            end
            ST_GAP: begin
`ifdef PADS_CFG_READBACK_EN
               state <= rd_phase ? ST_RD : ST_WR;
`else
               state <= ST_WR;
`endif
            end
`ifdef PADS_CFG_READBACK_EN
            ST_RD: begin
               if (wbm_ack_i) begin
                  rd_phase <= 1'b0;
                  if (wbm_dat_i[0] != mask_q[idx]) begin
                     err     <= 1'b1;
                     err_idx <= idx;
                     state   <= ST_FIN;
                  end else if (last_pad) begin
                     state <= ST_FIN;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= ST_GAP;
                  end
               end else if (t_expired) begin
                  err     <= 1'b1;
                  err_idx <= idx;
                  state   <= ST_FIN;
               end
            end
`endif
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Bus outputs decode straight from state so reset drops cyc/stb at once.
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN);
   assign wbm_cyc_o = xfer;
   assign wbm_stb_o = xfer;
   assign wbm_we_o  = (state == ST_WR);
   assign wbm_sel_o = xfer ? 4'hF : 4'h0;
   assign wbm_adr_o = xfer ? pad_addr(BASE_ADDR, idx) : 32'h0;
   assign wbm_dat_o = (state == ST_WR) ? {31'b0, mask_q[idx]} : 32'h0;

endmodule

// File: tb/tb_pads_cfg_seq.sv
// Directed bench for pads_cfg_seq: registered-ack responder, write log,
// and immediate-assertion checks of sequencing, timeout, reset and stall.
module tb_pads_cfg_seq;

   localparam int N = 38;
`ifdef PADS_CFG_READBACK_EN
   localparam int XFERS = 2;
`else
   localparam int XFERS = 1;
`endif
   localparam int PER_PAD = 3 * XFERS;
   localparam int BUDGET  = 4000;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        start = 1'b0;
   logic [43:0] oen_mask = '0;
   logic        busy, done, err;
   logic [5:0]  err_idx;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack;
   logic [31:0] rdat;

   int total = 0;
   int bad   = 0;

   // Responder controls
   int          stall = 0;
   logic        hold_en = 1'b0;
   logic [5:0]  hold_idx = 6'd0;
   logic        bad_en = 1'b0;
   logic [5:0]  bad_idx = 6'd0;
   logic        log_clr = 1'b0;

   always #5 clk = ~clk;

   pads_cfg_seq #(
      .NUM_PADS  (N),
      .BASE_ADDR (32'h3000_6000),
      .TIMEOUT   (16)
   ) dut (
      .clk       (clk),
      .resetb    (resetb),
      .start     (start),
      .oen_mask  (oen_mask),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_idx   (err_idx),
      .wbm_cyc_o (cyc),
      .wbm_stb_o (stb),
      .wbm_we_o  (we),
      .wbm_sel_o (sel),
      .wbm_adr_o (adr),
      .wbm_dat_o (dat_o),
      .wbm_ack_i (ack),
      .wbm_dat_i (rdat)
   );

   // Registered-ack responder with optional stall, withheld pad, corrupt read.
   int   wcnt;
   logic pad_val [0:63];
   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         ack  <= 1'b0;
         wcnt <= 0;
         rdat <= '0;
      end else begin
         ack <= 1'b0;
         if (cyc && stb && !ack && !(hold_en && adr[7:0] == {2'b0, hold_idx})) begin
            if (wcnt == stall) begin
               ack  <= 1'b1;
               wcnt <= 0;
               if (we) pad_val[adr[5:0]] <= dat_o[0];
               else rdat <= {31'b0, pad_val[adr[5:0]] ^ (bad_en && adr[7:0] == {2'b0, bad_idx})};
            end else begin
               wcnt <= wcnt + 1;
            end
         end else begin
            wcnt <= 0;
         end
      end
   end

   // Bus monitor: write log, gap cycles, cycles spent on the withheld pad.
   int          wr_cnt, gap_cnt, hold_cyc, proto_bad;
   logic [31:0] wr_adr [0:63];
   logic        wr_dat [0:63];
   always @(posedge clk) begin
      if (log_clr) begin
         wr_cnt    <= 0;
         gap_cnt   <= 0;
         hold_cyc  <= 0;
         proto_bad <= 0;
      end else begin
         if (cyc && we && ack && wr_cnt < 64) begin
            wr_adr[wr_cnt] <= adr;
            wr_dat[wr_cnt] <= dat_o[0];
            wr_cnt <= wr_cnt + 1;
         end
         if (busy && !cyc && !done) gap_cnt <= gap_cnt + 1;
         if (cyc && adr[7:0] == {2'b0, hold_idx}) hold_cyc <= hold_cyc + 1;
         if (stb !== cyc || sel !== (cyc ? 4'hF : 4'h0)) proto_bad <= proto_bad + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_clr = 1'b1;
      tick();
      log_clr = 1'b0;
   endtask

   // Cycle count n: the cycle in which start is high is cycle 1; returns the
   // number of the cycle in which done is seen high.
   task automatic run_seq(input logic [43:0] m, output int n);
      oen_mask = m;
      start = 1'b1;
      n = 1;
      tick();
      n = 2;
      start = 1'b0;
      while (done !== 1'b1 && n < BUDGET) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [43:0] mask1, mask_a, mask_b, mask_c;
   int          n, errs, hits;
   logic        found;

   initial begin
      mask1  = 44'h0_003F_C000_0021;
      mask_a = 44'hA5A_5A5A_5A5A;
      mask_b = ~mask_a;
      mask_c = 44'h123_4567_89AB;

      // Reset values
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_err_idx", err_idx, 6'd0);
      check("rst_cyc", cyc, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_sel", sel, 4'h0);
      check("rst_adr", adr, 32'h0);
      check("rst_dat", dat_o, 32'h0);
      tick();
      resetb = 1'b1;
      tick();
      clear_log();

      // Nominal sequence
      run_seq(mask1, n);
      check("t1_done", done, 1'b1);
      check("t1_latency", n, PER_PAD * N + 1);
      check("t1_err", err, 1'b0);
      tick();
      check("t1_done_pulse", done, 1'b0);
      check("t1_busy_low", busy, 1'b0);
      check("t1_wr_cnt", wr_cnt, N);
      for (int i = 0; i < N; i++) begin
         check($sformatf("t1_adr%0d", i), wr_adr[i], 32'h3000_6000 + i);
         check($sformatf("t1_dat%0d", i), wr_dat[i], mask1[i]);
      end
      check("t1_proto", proto_bad, 0);

      // Ack withheld at pad 5
      clear_log();
      hold_idx = 6'd5;
      hold_en  = 1'b1;
      run_seq(mask1, n);
      check("t2_done", done, 1'b1);
      check("t2_latency", n, 5 * PER_PAD + 16 + 2);
      check("t2_err", err, 1'b1);
      check("t2_err_idx", err_idx, 6'd5);
      check("t2_hold_cycles", hold_cyc, 16);
      check("t2_wr_cnt", wr_cnt, 5);
      check("t2_last_adr", wr_adr[4], 32'h3000_6004);
      hits = 0;
      for (int i = 0; i < wr_cnt; i++) if (wr_adr[i] == 32'h3000_6006) hits++;
      check("t2_no_6006", hits, 0);
      tick();
      check("t2_cyc_idle", cyc, 1'b0);
      check("t2_err_sticky", err, 1'b1);
      hold_en = 1'b0;

      // Start pulsed again at pad 10
      clear_log();
      oen_mask = mask_a;
      start = 1'b1;
      n = 1;
      tick();
      n = 2;
      start = 1'b0;
      check("t3_err_cleared", err, 1'b0);
      while (!(cyc === 1'b1 && adr === 32'h3000_600A) && n < BUDGET) begin
         tick();
         n++;
      end
      check("t3_reach_pad10", adr, 32'h3000_600A);
      oen_mask = mask_b;
      start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      while (done !== 1'b1 && n < BUDGET) begin
         tick();
         n++;
      end
      check("t3_done", done, 1'b1);
      check("t3_latency", n, PER_PAD * N + 1);
      check("t3_err", err, 1'b0);
      check("t3_wr_cnt", wr_cnt, N);
      errs = 0;
      for (int i = 0; i < N; i++) if (wr_dat[i] !== mask_a[i]) errs++;
      check("t3_mask_kept", errs, 0);
      tick();
      check("t3_idle", busy, 1'b0);

      // Reset asserted during the write to pad 20
      clear_log();
      oen_mask = mask_c;
      start = 1'b1;
      n = 1;
      tick();
      start = 1'b0;
      while (!(cyc === 1'b1 && we === 1'b1 && adr === 32'h3000_6014) && n < BUDGET) begin
         tick();
         n++;
      end
      check("t4_reach_pad20", adr, 32'h3000_6014);
      #2;
      resetb = 1'b0;
      #1;
      check("t4_cyc_async", cyc, 1'b0);
      check("t4_stb_async", stb, 1'b0);
      check("t4_busy_async", busy, 1'b0);
      check("t4_done_async", done, 1'b0);
      check("t4_err_async", err, 1'b0);
      check("t4_sel_async", sel, 4'h0);
      tick();
      tick();
      resetb = 1'b1;
      tick();
      clear_log();
      run_seq(mask_c, n);
      check("t4_done", done, 1'b1);
      check("t4_latency", n, PER_PAD * N + 1);
      check("t4_first_adr", wr_adr[0], 32'h3000_6000);
      check("t4_wr_cnt", wr_cnt, N);
      check("t4_last_adr", wr_adr[N-1], 32'h3000_6025);
      check("t4_err", err, 1'b0);
      tick();

      // Responder stalls 3 cycles per transfer
      clear_log();
      stall = 3;
      run_seq(mask1, n);
      check("t5_done", done, 1'b1);
      check("t5_latency", n, (3 + 3) * XFERS * N + 1);
      check("t5_err", err, 1'b0);
      check("t5_wr_cnt", wr_cnt, N);
      check("t5_gaps", gap_cnt, XFERS * N - 1);
      check("t5_proto", proto_bad, 0);
      stall = 0;
      tick();

`ifdef PADS_CFG_READBACK_EN
      // Wrong readback data at pad 7
      clear_log();
      bad_idx = 6'd7;
      bad_en  = 1'b1;
      run_seq(mask1, n);
      check("t6_done", done, 1'b1);
      check("t6_latency", n, 7 * PER_PAD + 5 + 2);
      check("t6_err", err, 1'b1);
      check("t6_err_idx", err_idx, 6'd7);
      check("t6_wr_cnt", wr_cnt, 8);
      check("t6_last_adr", wr_adr[7], 32'h3000_6007);
      bad_en = 1'b0;
      tick();
`endif

      found = (busy === 1'b0);
      check("end_idle", found, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
